// File: rtl/audio_sample_streamer.sv
// Avalon-MM fed stereo PCM FIFO that streams left/right samples to the audio core DAC sink.
// Status/control registers, low-water irq and underrun/overflow accounting.
module audio_sample_streamer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [1:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [DATA_W-1:0] left_data,
  output logic              left_valid,
  input  logic              left_ready,
  output logic [DATA_W-1:0] right_data,
  output logic              right_valid,
  input  logic              right_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic              enable, irq_en, ovf, unf;
  logic [15:0]       threshold, unf_cnt;

  logic cs_wr, push_req, ctrl_wr, flush, clr_wr;
  logic empty, full, push, pop, both_done, underrun;

  always_comb begin
    cs_wr     = chipselect & write;
    push_req  = cs_wr & (address == 2'd0);
    ctrl_wr   = cs_wr & (address == 2'd2);
    clr_wr    = cs_wr & (address == 2'd3);
    flush     = ctrl_wr & writedata[2];
    empty     = (level == '0);
    full      = (level == FULL_LVL);
    push      = push_req & ~full & ~flush;
    both_done = (~left_valid | left_ready) & (~right_valid | right_ready);
    pop       = enable & ~empty &
                ((state == IDLE) | ((state == PRESENT) & both_done));
    underrun  = (state == IDLE) & enable & empty & left_ready & right_ready;
  end

  // Plain RAM: no reset, one-cycle read latency into rd_word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata;
    if (pop)  rd_word <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      unf_cnt   <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      // A flush discards stored words; a word already popped into rd_word still goes out.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end

      if (ctrl_wr) begin
        enable    <= writedata[0];
        irq_en    <= writedata[1];
        threshold <= writedata[31:16];
      end

      if (clr_wr) begin
        ovf     <= 1'b0;
        unf     <= 1'b0;
        unf_cnt <= '0;
      end else begin
        if (push_req & full & ~flush) ovf <= 1'b1;
        if (underrun) begin
          unf <= 1'b1;
          if (unf_cnt != 16'hFFFF) unf_cnt <= unf_cnt + 1'b1;
        end
      end

      irq <= enable & irq_en & (16'(level) < threshold);

      if (chipselect & read) begin
        case (address)
          2'd1:    readdata <= {11'b0, irq, unf, ovf, full, empty, 16'(level)};
          2'd2:    readdata <= {threshold, 14'b0, irq_en, enable};
          2'd3:    readdata <= {16'b0, unf_cnt};
          default: readdata <= '0;
        endcase
      end
    end
  end

  // Output FSM; valid bits double as the inverted per-channel done flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      left_data   <= '0;
      right_data  <= '0;
      left_valid  <= 1'b0;
      right_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) state <= LOAD;
        LOAD: begin
          left_data   <= DATA_W'(rd_word[31:16]);
          right_data  <= DATA_W'(rd_word[15:0]);
          left_valid  <= 1'b1;
          right_valid <= 1'b1;
          state       <= PRESENT;
        end
        PRESENT: begin
          if (both_done) begin
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            state       <= pop ? LOAD : IDLE;
          end else begin
            left_valid  <= left_valid & ~left_ready;
            right_valid <= right_valid & ~right_ready;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer: register map, streaming, backpressure,
// overflow/underrun accounting, low-water irq and flush during presentation.
module tb_audio_sample_streamer;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect, write, read;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        irq;
  logic [15:0] left_data, right_data;
  logic        left_valid, right_valid, left_ready, right_ready;

  int checks = 0;
  int errors = 0;

  audio_sample_streamer dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .read(read), .readdata(readdata),
    .irq(irq), .left_data(left_data), .left_valid(left_valid), .left_ready(left_ready),
    .right_data(right_data), .right_valid(right_valid), .right_ready(right_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic chk_valids(input string tag, input logic lv, input logic rv);
    chk(tag, {30'b0, left_valid, right_valid}, {30'b0, lv, rv});
  endtask

  initial begin
    logic [31:0] rd;
    int got;

    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; left_ready = 1'b0; right_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    bus_read(2'd1, rd);
    chk("rst_status", rd, 32'h0001_0000);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk_valids("rst_valids", 1'b0, 1'b0);

    // Two words, full-rate streaming
    left_ready = 1'b1; right_ready = 1'b1;
    bus_write(2'd0, 32'h1234_5678);
    bus_write(2'd0, 32'h9ABC_DEF0);
    bus_write(2'd2, 32'h1);
    tick();
    chk_valids("stream_load1", 1'b0, 1'b0);
    tick();
    chk_valids("stream_pres1", 1'b1, 1'b1);
    chk("stream_data1", {left_data, right_data}, 32'h1234_5678);
    tick();
    chk_valids("stream_load2", 1'b0, 1'b0);
    tick();
    chk_valids("stream_pres2", 1'b1, 1'b1);
    chk("stream_data2", {left_data, right_data}, 32'h9ABC_DEF0);
    tick();
    chk_valids("stream_done", 1'b0, 1'b0);
    left_ready = 1'b0; right_ready = 1'b0;
    bus_read(2'd1, rd);
    chk("stream_status", rd, 32'h0001_0000);

    // Overflow: DEPTH+3 pushes while disabled, then drain in order
    bus_write(2'd2, 32'h0);
    for (int i = 0; i < DEPTH + 3; i++) bus_write(2'd0, {16'(i), ~16'(i)});
    bus_read(2'd1, rd);
    chk("ovf_status", rd, 32'h0006_0100);
    left_ready = 1'b1; right_ready = 1'b1;
    bus_write(2'd2, 32'h1);
    got = 0;
    for (int c = 0; c < 2000 && got < DEPTH; c++) begin
      tick();
      if (left_valid) begin
        chk("drain_word", {left_data, right_data}, {16'(got), ~16'(got)});
        got++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (left_valid) got++;
    end
    chk("drain_count", got, DEPTH);
    left_ready = 1'b0; right_ready = 1'b0;
    bus_write(2'd2, 32'h0);
    bus_read(2'd1, rd);
    chk("drain_status", rd, 32'h000D_0000);
    bus_write(2'd3, 32'h0);

    // Skewed ready: right channel stalls
    bus_write(2'd0, 32'hAAAA_5555);
    bus_write(2'd0, 32'h1111_2222);
    left_ready = 1'b1; right_ready = 1'b0;
    bus_write(2'd2, 32'h1);
    tick();
    chk_valids("skew_load", 1'b0, 1'b0);
    tick();
    chk_valids("skew_pres", 1'b1, 1'b1);
    chk("skew_data", {left_data, right_data}, 32'hAAAA_5555);
    tick();
    chk_valids("skew_left_done", 1'b0, 1'b1);
    bus_read(2'd1, rd);
    chk("skew_level_hold", rd, 32'h0000_0001);
    chk_valids("skew_hold1", 1'b0, 1'b1);
    tick();
    tick();
    chk_valids("skew_hold2", 1'b0, 1'b1);
    chk("skew_rdata_stable", {16'b0, right_data}, 32'h0000_5555);
    right_ready = 1'b1;
    tick();
    chk_valids("skew_reload", 1'b0, 1'b0);
    tick();
    chk_valids("skew_pres2", 1'b1, 1'b1);
    chk("skew_data2", {left_data, right_data}, 32'h1111_2222);
    tick();
    chk_valids("skew_idle", 1'b0, 1'b0);
    left_ready = 1'b0; right_ready = 1'b0;
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'h0);

    // Underrun counting and clear
    bus_write(2'd2, 32'h1);
    left_ready = 1'b1; right_ready = 1'b1;
    repeat (10) tick();
    left_ready = 1'b0; right_ready = 1'b0;
    bus_read(2'd3, rd);
    chk("unf_count", rd, 32'd10);
    bus_read(2'd1, rd);
    chk("unf_status", rd, 32'h0009_0000);
    bus_write(2'd3, 32'hDEAD_BEEF);
    bus_read(2'd3, rd);
    chk("unf_cleared", rd, 32'd0);
    bus_read(2'd1, rd);
    chk("unf_status_clr", rd, 32'h0001_0000);
    bus_write(2'd2, 32'h0);

    // Low-water irq while draining, then flush during PRESENT
    for (int k = 0; k < 5; k++) bus_write(2'd0, {16'h1000 + 16'(k), 16'h2000 + 16'(k)});
    bus_write(2'd2, 32'h0004_0003);
    tick();
    tick();
    chk("irq_lvl4", {31'b0, irq}, 32'h0);
    chk_valids("irq_pres1", 1'b1, 1'b1);
    left_ready = 1'b1; right_ready = 1'b1;
    tick();
    left_ready = 1'b0; right_ready = 1'b0;
    chk("irq_lvl3_same_cycle", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_rise", {31'b0, irq}, 32'h1);
    chk_valids("flush_pres", 1'b1, 1'b1);
    chk("flush_data", {left_data, right_data}, 32'h1001_2001);
    bus_write(2'd2, 32'h0004_0007);
    chk_valids("flush_hold", 1'b1, 1'b1);
    bus_read(2'd1, rd);
    chk("flush_status", rd, 32'h0011_0000);
    bus_read(2'd2, rd);
    chk("ctrl_readback", rd, 32'h0004_0003);
    chk("flush_data_stable", {left_data, right_data}, 32'h1001_2001);
    left_ready = 1'b1; right_ready = 1'b1;
    tick();
    left_ready = 1'b0; right_ready = 1'b0;
    chk_valids("flush_word_done", 1'b0, 1'b0);
    tick();
    chk_valids("flush_no_more", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
